uart_fir_stream_ctrl: RTL
=========================

# uart_fir_stream_ctrl

Parametrised UART-to-FIR streaming controller. It replaces the fixed two-byte load / single-result control path between the UART receiver/transmitter and the FIR filter datapath. It assembles IN_BYTES received bytes into one FIR input sample and buffers FIR results in an output FIFO, so reception continues while the transmitter is busy. Each result is serialised as OUT_BYTES UART bytes. It sits between the UART RX/TX cores and the FIR filter inside the top-level FIR system.

## Interface
- IN_BYTES, 2: bytes per FIR input sample, received LSB first; valid range 1..4.
- OUT_W, 24: FIR output width; must satisfy OUT_W <= 8*OUT_BYTES.
- OUT_BYTES, 3: bytes transmitted per FIR result, LSB first; valid range 1..8.
- FIFO_DEPTH, 4: output FIFO entries; must be a power of 2, >= 2.
- TIMEOUT_CYC, 65535: inter-byte idle limit in clocks (only used with RX_TIMEOUT_EN).

Ports:
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- KEY  in  1  reset; asynchronous, active-low.
- rx_data  in  8  received UART byte; valid when rx_data_ready=1.
- rx_data_ready  in  1  one-cycle pulse per received byte.
- fir_in  out  8*IN_BYTES  assembled sample; reset 0; holds until the next sample completes.
- fir_in_valid  out  1  one-cycle pulse when fir_in is updated; reset 0.
- fir_out  in  OUT_W  FIR result, two's complement.
- fir_out_valid  in  1  one-cycle pulse when fir_out is valid.
- tx_data  out  8  byte to the UART TX; reset 0.
- tx_start  out  1  one-cycle transmit request; reset 0.
- tx_busy  in  1  UART TX busy.
- overflow  out  1  sticky; set when a result is dropped because the FIFO is full; reset 0.
- rx_timeout  out  1  sticky; set when a partial sample times out; reset 0; tied 0 without RX_TIMEOUT_EN.

## Operation
- RX assembler:
  - A byte counter runs 0..IN_BYTES-1; byte k is written to fir_in bits [8k+7:8k] of a staging register.
  - On the last byte, the staging register is copied to fir_in, fir_in_valid pulses, and the counter wraps to 0.
- Result capture:
  - On fir_out_valid, fir_out is sign-extended to 8*OUT_BYTES bits and pushed into the FIFO.
  - If the FIFO is full and no pop occurs that cycle, the result is dropped and overflow is set.
  - If a push and a pop occur in the same cycle, both take effect, including when the FIFO is full.
- TX FSM states are IDLE, SEND, WAIT_ACK, WAIT_DONE.
  - IDLE: if the FIFO is non-empty, pop into the shift register, set idx=0, go to SEND.
  - SEND: drive tx_data = byte[idx]. When tx_busy=0, assert tx_start for one cycle and go to WAIT_ACK.
  - WAIT_ACK: wait for tx_busy=1, then go to WAIT_DONE.
  - WAIT_DONE: wait for tx_busy=0. If idx=OUT_BYTES-1, go to IDLE; otherwise idx++ and go to SEND.
  - tx_data is held stable from SEND until WAIT_DONE exits.
- The shift register is separate from the FIFO, so FIFO_DEPTH+1 results can be outstanding.
- Sticky flags clear only on reset.
- Reset mid-operation:
  - All state, counters, FIFO pointers and flags clear immediately (asynchronously).
  - A partial sample is discarded; tx_start drops to 0.

## Timing
- fir_in and fir_in_valid update in cycle N+1 when the final rx_data_ready is in cycle N.
- fir_out_valid in cycle N with an empty FIFO, FSM in IDLE and tx_busy=0:
  - FIFO is non-empty in N+1 and IDLE pops it;
  - tx_start is asserted in N+2.
- At most one tx_start is issued per UART byte. tx_start is never asserted while tx_busy=1.
- rx_data_ready and fir_out_valid in the same cycle are handled independently.

## Configuration
- RX_TIMEOUT_EN defined:
  - An idle counter clears on every rx_data_ready.
  - If the byte counter is nonzero and the idle counter reaches TIMEOUT_CYC, the byte counter resets to 0, the partial sample is discarded and rx_timeout is set.
  - If an rx_data_ready arrives in the timeout cycle, that byte is taken as byte 0 of a new sample.
- Undefined: no idle counter; a partial sample waits indefinitely; rx_timeout is constant 0.

## Test plan
- IN_BYTES=2, rx 0x34 then 0x12 -> fir_in=16'h1234 with a single-cycle fir_in_valid one cycle after the second rx_data_ready.
- OUT_W=24, OUT_BYTES=4, fir_out=24'hABCDEF -> tx bytes EF, CD, AB, FF in order; each tx_start only after tx_busy has fallen.
- FIFO_DEPTH=4, tx_busy held high, 6 fir_out_valid pulses (values 1..6) -> overflow=1, 6th result dropped; after release, results 1..5 are sent in order.
- RX_TIMEOUT_EN, TIMEOUT_CYC=16, one byte 0xAA then 20 idle cycles -> rx_timeout=1. Bytes 0x01, 0x02 then give fir_in=16'h0201.
- KEY low during WAIT_DONE with 2 results queued -> tx_start=0 and flags 0 immediately; after release, no bytes are sent.
- FIFO full, fir_out_valid in the same cycle as an IDLE pop -> result accepted, overflow stays 0, all results are sent in order.

Source files
------------

// File: rtl/uart_fir_stream_ctrl.sv
// rtl/uart_fir_stream_ctrl.sv - UART-to-FIR streaming controller; define RX_TIMEOUT_EN for the inter-byte timeout
module uart_fir_stream_ctrl #(
    parameter int IN_BYTES    = 2,
    parameter int OUT_W       = 24,
    parameter int OUT_BYTES   = 3,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                  CLOCK_50,
    input  logic                  KEY,
    input  logic [7:0]            rx_data,
    input  logic                  rx_data_ready,
    output logic [8*IN_BYTES-1:0] fir_in,
    output logic                  fir_in_valid,
    input  logic [OUT_W-1:0]      fir_out,
    input  logic                  fir_out_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    output logic                  overflow,
    output logic                  rx_timeout
);
    localparam int IW = 8 * IN_BYTES;
    localparam int OW = 8 * OUT_BYTES;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [2:0] IN_LAST  = 3'(IN_BYTES - 1);
    localparam logic [2:0] OUT_LAST = 3'(OUT_BYTES - 1);

    if (IN_BYTES < 1 || IN_BYTES > 4 || OUT_BYTES < 1 || OUT_BYTES > 8 || OUT_W > OW ||
        FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYC < 1) begin : g_bad_params
        $error("uart_fir_stream_ctrl: invalid parameter set");
    end

    typedef enum logic [1:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE} tx_state_t;

    // RX assembler
    logic [2:0]    byte_cnt;
    logic [2:0]    cnt_base;
    logic [IW-1:0] staging;
    logic [IW-1:0] stage_next;
    logic          rx_restart;

    // A timeout in the same cycle as a byte makes that byte the first of a new sample.
    always_comb begin
        cnt_base   = rx_restart ? 3'd0 : byte_cnt;
        stage_next = staging;
        stage_next[{cnt_base, 3'b000} +: 8] = rx_data;
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            byte_cnt     <= 3'd0;
            staging      <= '0;
            fir_in       <= '0;
            fir_in_valid <= 1'b0;
        end else begin
            fir_in_valid <= 1'b0;
            if (rx_restart)
                byte_cnt <= 3'd0;
            if (rx_data_ready) begin
                if (cnt_base == IN_LAST) begin
                    fir_in       <= stage_next;
                    fir_in_valid <= 1'b1;
                    byte_cnt     <= 3'd0;
                end else begin
                    staging  <= stage_next;
                    byte_cnt <= cnt_base + 3'd1;
                end
            end
        end
    end

`ifdef RX_TIMEOUT_EN
    logic [31:0] idle_cnt;

    assign rx_restart = (byte_cnt != 3'd0) && (idle_cnt == 32'(TIMEOUT_CYC));

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            idle_cnt   <= '0;
            rx_timeout <= 1'b0;
        end else begin
            if (rx_data_ready)
                idle_cnt <= '0;
            else if (idle_cnt != 32'(TIMEOUT_CYC))
                idle_cnt <= idle_cnt + 32'd1;
            if (rx_restart)
                rx_timeout <= 1'b1;
        end
    end
`else
    assign rx_restart = 1'b0;
    assign rx_timeout = 1'b0;
`endif

    // Result FIFO, one extra pointer bit distinguishes full from empty
    tx_state_t     state;
    tx_state_t     state_next;
    logic [OW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [OW-1:0] fir_ext;
    logic          fifo_empty;
    logic          fifo_full;
    logic          push;
    logic          pop;

    assign fir_ext    = OW'($signed(fir_out));
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop        = (state == IDLE) && !fifo_empty;
    assign push       = fir_out_valid && (!fifo_full || pop);

    always_ff @(posedge CLOCK_50) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= fir_ext;
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (fir_out_valid && !push)
                overflow <= 1'b1;
        end
    end

    // TX serialiser: shift register holds the result being sent, outside the FIFO
    logic [OW-1:0] shift_reg;
    logic [2:0]    idx;

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY) begin
            shift_reg <= '0;
            idx       <= 3'd0;
        end else begin
            if (pop) begin
                shift_reg <= mem[rd_ptr[AW-1:0]];
                idx       <= 3'd0;
            end else if (state == WAIT_DONE && !tx_busy && idx != OUT_LAST) begin
                idx <= idx + 3'd1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge KEY) begin
        if (!KEY)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!fifo_empty) state_next = SEND;
            SEND:      if (!tx_busy)    state_next = WAIT_ACK;
            WAIT_ACK:  if (tx_busy)     state_next = WAIT_DONE;
            WAIT_DONE: if (!tx_busy)    state_next = (idx == OUT_LAST) ? IDLE : SEND;
            default:                    state_next = IDLE;
        endcase
    end

    always_comb begin
        tx_start = (state == SEND) && !tx_busy;
        tx_data  = (state == IDLE) ? 8'h00 : shift_reg[{idx, 3'b000} +: 8];
    end
endmodule
